tetromino_rng: RTL and testbench
================================

TETROMINO_RNG -- requirements
Module: tetromino_rng

Interface
REQ-001 Parameter SAMPLE_DIV, default 4: raw-bit sample period in clk cycles, legal range 2..255.
REQ-002 Parameter RUN_LIMIT, default 32: consecutive identical raw samples that trip the health alarm, legal range 4..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; 0 sampled on a clk edge resets the block.
REQ-005 random_bit  input  1  raw entropy bit from the ring-oscillator source, already two-flop synchronised, free-running.
REQ-006 piece_ready  input  1  consumer accepts piece this cycle.
REQ-007 piece_valid  output  1  piece holds a valid tetromino index.
REQ-008 piece  output  3  tetromino index 0..6 (piece_t); never 7 while piece_valid=1.
REQ-009 health_fail  output  1  sticky entropy-health alarm.

Function
REQ-010 A sample counter shall count 0..SAMPLE_DIV-1 and wrap; random_bit shall be sampled only in the cycle the counter equals SAMPLE_DIV-1.
REQ-011 Samples shall be paired in order (first, second); pair 01 shall yield whitened bit 0, pair 10 shall yield whitened bit 1, and pairs 00/11 shall yield nothing.
REQ-012 Whitened bits shall shift MSB-first into a 3-bit candidate with a 0..3 bit count; the candidate is complete at count 3.
REQ-013 A complete candidate of 7 shall be discarded and the count cleared in the same cycle (rejection sampling).
REQ-014 A complete candidate equal to the last delivered piece shall be discarded once; the next complete candidate in 0..6 shall be accepted unconditionally (NES single-reroll rule); the reroll flag shall clear on every accept.
REQ-015 Accept: a complete candidate in 0..6, not consumed by REQ-014, shall load piece and set piece_valid on the next edge when the output slot is empty or piece_valid&piece_ready this cycle.
REQ-016 Handshake: a transfer occurs on an edge where piece_valid&piece_ready=1; piece shall remain stable while piece_valid=1 and piece_ready=0.
REQ-017 Transfer without simultaneous accept shall clear piece_valid on the next edge; transfer with simultaneous accept shall keep piece_valid=1 and present the new piece (no bubble).
REQ-018 The last-delivered register shall update to piece on each transfer and shall reset to 7 (no match possible).
REQ-019 Stall: while a complete accepted-eligible candidate waits for the slot, further whitened bits shall be dropped; sampling and pairing shall continue.
REQ-020 A run counter shall count consecutive identical raw samples, saturating at RUN_LIMIT; reaching RUN_LIMIT shall set health_fail, which shall stay 1 until reset.
REQ-021 health_fail shall not block piece generation; it is report-only.
REQ-022 piece_ready while piece_valid=0 shall have no effect.

Reset
REQ-023 While reset=0: piece_valid=0, piece=0, health_fail=0, sample counter=0, pair state empty, candidate count=0, reroll flag=0, run counter=0, last-delivered=7.
REQ-024 Reset asserted mid-operation shall discard any held piece, partial pair and partial candidate on that edge; the first sample after release occurs SAMPLE_DIV cycles after the first cycle with reset=1.

Structure
REQ-025 Shared package tetris_pkg shall hold piece_t (I=0,O=1,T=2,S=3,Z=4,J=5,L=6) and PIECE_NONE=7.
REQ-026 The pair extractor (REQ-011) shall be a sub-module von_neumann_extractor with sample_en/bit inputs and wbit_valid/wbit outputs.

Verification
REQ-027 SAMPLE_DIV=4, random_bit pattern giving samples 0,1,1,0,0,1 with piece_ready=1 -> candidate 010; piece=2 (T), piece_valid=1 for exactly one cycle.
REQ-028 Samples encoding whitened 1,1,1 then 0,1,1 -> first candidate (7) rejected, no valid; piece=3 (S) delivered next.
REQ-029 Deliver piece 4 (Z), then whitened 100,100,001 -> first 100 rerolled, second 100 accepted as Z, later piece=1 (O).
REQ-030 piece_ready=0 for 200 cycles with a piece held -> piece and piece_valid stable throughout; raising piece_ready for one cycle with a complete candidate pending -> back-to-back valid, new value next cycle.
REQ-031 random_bit held at 1, RUN_LIMIT=32 -> health_fail=1 at the 32nd sample, no piece produced, health_fail stays 1 until reset=0.
REQ-032 reset=0 for one cycle while piece_valid=1 and a partial candidate is held -> all outputs at REQ-023 values next cycle; first new sample SAMPLE_DIV cycles after the first reset=1 cycle.

Source files
------------

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared tetromino index type and helpers
package tetris_pkg;

  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_t;

  localparam logic [2:0] PIECE_NONE = 3'd7;

  function automatic logic is_piece(input logic [2:0] code);
    return code != PIECE_NONE;
  endfunction

endpackage

// File: rtl/von_neumann_extractor.sv
// rtl/von_neumann_extractor.sv - pairs raw samples and emits debiased bits
module von_neumann_extractor (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic raw_bit,
  output logic wbit_valid,
  output logic wbit
);

  logic have_first;
  logic first_bit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      have_first <= 1'b0;
      first_bit  <= 1'b0;
    end else if (sample_en) begin
      have_first <= !have_first;
      if (!have_first) first_bit <= raw_bit;
    end
  end

  // Pair 01 gives 0 and 10 gives 1, so the output is simply the first sample.
  assign wbit_valid = sample_en && have_first && (first_bit != raw_bit);
  assign wbit       = first_bit;

endmodule

// File: rtl/tetromino_rng.sv
// rtl/tetromino_rng.sv - whitened-entropy tetromino generator with single reroll
module tetromino_rng
  import tetris_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 4,
  parameter int unsigned RUN_LIMIT  = 32
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   random_bit,
  input  logic   piece_ready,
  output logic   piece_valid,
  output piece_t piece,
  output logic   health_fail
);

  localparam logic [7:0] DIV_LAST = 8'(SAMPLE_DIV - 1);
  localparam logic [7:0] RUN_MAX  = 8'(RUN_LIMIT);

  logic [7:0] div_cnt;
  logic       sample_en;

  assign sample_en = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!reset)         div_cnt <= '0;
    else if (sample_en) div_cnt <= '0;
    else                div_cnt <= div_cnt + 8'd1;
  end

  logic wbit_valid;
  logic wbit;

  von_neumann_extractor u_extractor (
    .clk        (clk),
    .reset      (reset),
    .sample_en  (sample_en),
    .raw_bit    (random_bit),
    .wbit_valid (wbit_valid),
    .wbit       (wbit)
  );

  // Health monitor watches raw samples, before whitening hides a stuck source.
  logic [7:0] run_cnt;
  logic [7:0] run_next;
  logic       prev_sample;

  always_comb begin
    run_next = run_cnt;
    if (run_cnt == 8'd0 || random_bit != prev_sample) run_next = 8'd1;
    else if (run_cnt != RUN_MAX)                      run_next = run_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_cnt     <= '0;
      prev_sample <= 1'b0;
      health_fail <= 1'b0;
    end else if (sample_en) begin
      run_cnt     <= run_next;
      prev_sample <= random_bit;
      if (run_next == RUN_MAX) health_fail <= 1'b1;
    end
  end

  logic [2:0] cand;
  logic [1:0] cand_cnt;
  logic       reroll;
  logic [2:0] last_piece;
  logic       complete;
  logic       is_reject;
  logic       is_reroll;
  logic       eligible;
  logic       slot_free;
  logic       accept;
  logic       transfer;
  logic       clear_cand;

  assign complete   = (cand_cnt == 2'd3);
  assign transfer   = piece_valid && piece_ready;
  assign slot_free  = !piece_valid || piece_ready;
  assign is_reject  = complete && !is_piece(cand);
  assign is_reroll  = complete && !is_reject && !reroll && (cand == last_piece);
  assign eligible   = complete && !is_reject && !is_reroll;
  assign accept     = eligible && slot_free;
  assign clear_cand = is_reject || is_reroll || accept;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cand        <= '0;
      cand_cnt    <= '0;
      reroll      <= 1'b0;
      last_piece  <= PIECE_NONE;
      piece_valid <= 1'b0;
      piece       <= PIECE_I;
    end else begin
      // A bit arriving as the old candidate retires starts the next one;
      // a stalled candidate drops it.
      if (clear_cand) begin
        cand     <= {2'b00, wbit && wbit_valid};
        cand_cnt <= {1'b0, wbit_valid};
      end else if (!complete && wbit_valid) begin
        cand     <= {cand[1:0], wbit};
        cand_cnt <= cand_cnt + 2'd1;
      end

      if (is_reroll)   reroll <= 1'b1;
      else if (accept) reroll <= 1'b0;

      if (transfer) last_piece <= piece;

      if (accept) begin
        piece       <= piece_t'(cand);
        piece_valid <= 1'b1;
      end else if (transfer) begin
        piece_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tetromino_rng.sv
// tb/tb_tetromino_rng.sv - self-checking bench for tetromino_rng
module tb_tetromino_rng;

  localparam int SD = 4;
  localparam int RL = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       random_bit = 1'b0;
  logic       piece_ready = 1'b0;
  logic       piece_valid;
  logic [2:0] piece;
  logic       health_fail;

  tetromino_rng #(.SAMPLE_DIV(SD), .RUN_LIMIT(RL)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .random_bit  (random_bit),
    .piece_ready (piece_ready),
    .piece_valid (piece_valid),
    .piece       (piece),
    .health_fail (health_fail)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: plain integers, pairing via a "first sample" slot.
  int m_cyc, m_first, m_cand, m_bits, m_reroll, m_last, m_valid, m_piece, m_health, m_run, m_prev;

  int dcnt, dfirst, dlast;
  int watch = 0;
  int stable_bad = 0;

  typedef struct {
    string       name;
    logic [31:0] samples;
    int          n;
    int          exp_cnt;
    int          exp_first;
    int          exp_last;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic b, input logic rdy);
    int wv, w, take, acc;
    if (!r) begin
      m_cyc = 0; m_first = -1; m_cand = 0; m_bits = 0; m_reroll = 0; m_last = 7;
      m_valid = 0; m_piece = 0; m_health = 0; m_run = 0; m_prev = 0;
      return;
    end
    wv = 0; w = 0;
    if (m_cyc % SD == SD - 1) begin
      if (m_first < 0) m_first = int'(b);
      else begin
        if (m_first != int'(b)) begin wv = 1; w = m_first; end
        m_first = -1;
      end
      if (m_run == 0 || int'(b) != m_prev) m_run = 1;
      else if (m_run < RL) m_run++;
      m_prev = int'(b);
      if (m_run == RL) m_health = 1;
    end
    m_cyc++;
    take = 0; acc = 0;
    if (m_bits == 3) begin
      if (m_cand == 7) take = 1;
      else if (m_reroll == 0 && m_cand == m_last) begin take = 1; m_reroll = 1; end
      else if (m_valid == 0 || rdy) begin take = 1; acc = 1; m_reroll = 0; end
    end
    if (m_valid == 1 && rdy) begin
      m_last = m_piece;
      if (acc == 0) m_valid = 0;
    end
    if (acc == 1) begin m_piece = m_cand; m_valid = 1; end
    if (take == 1) begin m_bits = wv; m_cand = wv * w; end
    else if (m_bits < 3 && wv == 1) begin m_cand = m_cand * 2 + w; m_bits++; end
  endtask

  task automatic step();
    if (rst_n && piece_valid && piece_ready) begin
      if (dcnt == 0) dfirst = int'(piece);
      dlast = int'(piece);
      dcnt++;
    end
    @(posedge clk);
    #1;
    model_edge(rst_n, random_bit, piece_ready);
    vectors++;
    if (piece_valid !== m_valid[0] || int'(piece) != m_piece || health_fail !== m_health[0]) begin
      miscompares++;
      $display("FAIL model_cmp t=%0t: valid/piece/health got %0d/%0d/%0d, expected %0d/%0d/%0d",
               $time, piece_valid, piece, health_fail, m_valid, m_piece, m_health);
    end
    if (watch != 0 && !(piece_valid && piece == 3'd2)) stable_bad++;
  endtask

  task automatic feed_sample(input logic b);
    random_bit = b;
    repeat (SD) step();
  endtask

  task automatic feed_bits(input logic [31:0] s, input int n);
    for (int i = n - 1; i >= 0; i--) feed_sample(s[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{"t_010",        32'b011001,                   6,  1, 2, 2};
    tbl[1] = '{"reject7_s",    32'b101010011010,             12, 1, 3, 3};
    tbl[2] = '{"reroll_z",     32'b100101100101100101010110, 24, 3, 4, 1};
    tbl[3] = '{"junk_pairs",   32'b00110111100010,           14, 1, 3, 3};
    tbl[4] = '{"i_reroll",     32'b010101010101,             12, 1, 0, 0};
    tbl[5] = '{"l_reroll",     32'b101001101001,             12, 1, 6, 6};
    tbl[6] = '{"reject2_j",    32'b101010101010100110,       18, 1, 5, 5};

    dcnt = 0; dfirst = -1; dlast = -1;
    do_reset();
    check("reset_valid", int'(piece_valid), 0);
    check("reset_piece", int'(piece), 0);
    check("reset_health", int'(health_fail), 0);

    for (int v = 0; v < 7; v++) begin
      piece_ready = 1'b1;
      do_reset();
      dcnt = 0; dfirst = -1; dlast = -1;
      feed_bits(tbl[v].samples, tbl[v].n);
      random_bit = 1'b0;
      repeat (12) step();
      check({tbl[v].name, "_count"}, dcnt, tbl[v].exp_cnt);
      check({tbl[v].name, "_first"}, dfirst, tbl[v].exp_first);
      check({tbl[v].name, "_last"}, dlast, tbl[v].exp_last);
    end

    // Long stall with a second candidate and dropped bits behind it.
    piece_ready = 1'b0;
    do_reset();
    feed_bits(32'b011001, 6);
    step();
    check("stall_first_valid", int'(piece_valid), 1);
    watch = 1;
    feed_bits(32'b100110, 6);
    feed_bits(32'b101010, 6);
    for (int i = 0; i < 38; i++) feed_sample(i[1]);
    watch = 0;
    check("stall_stable", stable_bad, 0);
    check("stall_piece", int'(piece), 2);
    random_bit = 1'b0;
    piece_ready = 1'b1;
    step();
    check("b2b_valid", int'(piece_valid), 1);
    check("b2b_piece", int'(piece), 5);
    piece_ready = 1'b0;
    step();
    check("b2b_hold", int'(piece), 5);
    piece_ready = 1'b1;
    step();
    check("drop_after_stall", int'(piece_valid), 0);
    repeat (8) step();

    // Stuck source trips the alarm exactly at the RL-th sample.
    do_reset();
    random_bit = 1'b1;
    repeat ((RL - 1) * SD) step();
    check("health_before", int'(health_fail), 0);
    repeat (SD) step();
    check("health_at_limit", int'(health_fail), 1);
    repeat (100) step();
    check("health_sticky", int'(health_fail), 1);
    check("stuck_no_piece", int'(piece_valid), 0);
    rst_n = 1'b0;
    step();
    check("health_cleared", int'(health_fail), 0);
    rst_n = 1'b1;

    // Reset mid-operation with a held piece and a partial candidate.
    piece_ready = 1'b0;
    do_reset();
    feed_bits(32'b011001, 6);
    step();
    feed_bits(32'b10, 2);
    rst_n = 1'b0;
    step();
    check("midreset_valid", int'(piece_valid), 0);
    check("midreset_piece", int'(piece), 0);
    check("midreset_health", int'(health_fail), 0);
    rst_n = 1'b1;
    piece_ready = 1'b1;
    feed_bits(32'b011001, 6);
    check("post_reset_not_yet", int'(piece_valid), 0);
    step();
    check("post_reset_valid", int'(piece_valid), 1);
    check("post_reset_piece", int'(piece), 2);

    // Randomised traffic against the model, with varying ready and source bias.
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 1000; i++) begin
        rst_n = ($urandom_range(0, 599) != 0);
        if (blk == 3) random_bit = ($urandom_range(0, 15) != 0);
        else          random_bit = 1'($urandom_range(0, 1));
        piece_ready = ($urandom_range(0, 3) < blk + 1);
        step();
        if (piece_valid) check("piece_in_range", int'(piece == 3'd7), 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
